fft16_result_streamer: RTL and testbench

Output-side companion to `FFT16_top`. It captures all 16 complex bins when the FFT signals a completed cycle and streams them out one bin per beat over a valid/ready handshake. It sits between `FFT16_top` and any serial consumer, such as a UART formatter, FIFO or magnitude post-processor. It frees the FFT to start its next cycle as soon as the snapshot is taken.

---
 rtl/fft16_result_streamer.sv | 145 ++++++++++++++
 tb/tb_fft16_result_streamer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_result_streamer.sv
// fft16_result_streamer: snapshots the 16 FFT16_top bins on a completion edge and streams them one bin per valid/ready beat.
// Optional feature macro: FFT16_STREAM_MAG_EN adds o_mag, an alpha-max-beta-min magnitude of the presented bin.
module fft16_result_streamer #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_FFT_cycle_done,
    input  logic [WORD_SIZE-1:0] in0_re,
    input  logic [WORD_SIZE-1:0] in0_im,
    input  logic [WORD_SIZE-1:0] in1_re,
    input  logic [WORD_SIZE-1:0] in1_im,
    input  logic [WORD_SIZE-1:0] in2_re,
    input  logic [WORD_SIZE-1:0] in2_im,
    input  logic [WORD_SIZE-1:0] in3_re,
    input  logic [WORD_SIZE-1:0] in3_im,
    input  logic [WORD_SIZE-1:0] in4_re,
    input  logic [WORD_SIZE-1:0] in4_im,
    input  logic [WORD_SIZE-1:0] in5_re,
    input  logic [WORD_SIZE-1:0] in5_im,
    input  logic [WORD_SIZE-1:0] in6_re,
    input  logic [WORD_SIZE-1:0] in6_im,
    input  logic [WORD_SIZE-1:0] in7_re,
    input  logic [WORD_SIZE-1:0] in7_im,
    input  logic [WORD_SIZE-1:0] in8_re,
    input  logic [WORD_SIZE-1:0] in8_im,
    input  logic [WORD_SIZE-1:0] in9_re,
    input  logic [WORD_SIZE-1:0] in9_im,
    input  logic [WORD_SIZE-1:0] in10_re,
    input  logic [WORD_SIZE-1:0] in10_im,
    input  logic [WORD_SIZE-1:0] in11_re,
    input  logic [WORD_SIZE-1:0] in11_im,
    input  logic [WORD_SIZE-1:0] in12_re,
    input  logic [WORD_SIZE-1:0] in12_im,
    input  logic [WORD_SIZE-1:0] in13_re,
    input  logic [WORD_SIZE-1:0] in13_im,
    input  logic [WORD_SIZE-1:0] in14_re,
    input  logic [WORD_SIZE-1:0] in14_im,
    input  logic [WORD_SIZE-1:0] in15_re,
    input  logic [WORD_SIZE-1:0] in15_im,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [3:0]           o_idx,
    output logic [WORD_SIZE-1:0] o_re,
    output logic [WORD_SIZE-1:0] o_im,
    output logic                 o_last,
    output logic                 o_busy,
`ifdef FFT16_STREAM_MAG_EN
    output logic [WORD_SIZE:0]   o_mag,
`endif
    output logic                 o_overrun
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic                 done_q;
    logic                 ovr_q, ovr_d;
    logic                 load_en;
    logic                 cap_evt;
    logic                 xfer;
    logic [WORD_SIZE-1:0] in_re [16];
    logic [WORD_SIZE-1:0] in_im [16];
    logic [WORD_SIZE-1:0] re_q [16];
    logic [WORD_SIZE-1:0] im_q [16];

    assign in_re = '{in0_re, in1_re, in2_re, in3_re, in4_re, in5_re, in6_re, in7_re,
                     in8_re, in9_re, in10_re, in11_re, in12_re, in13_re, in14_re, in15_re};
    assign in_im = '{in0_im, in1_im, in2_im, in3_im, in4_im, in5_im, in6_im, in7_im,
                     in8_im, in9_im, in10_im, in11_im, in12_im, in13_im, in14_im, in15_im};

    assign cap_evt = i_FFT_cycle_done & ~done_q;
    assign xfer    = (state_q == STREAM) & i_ready;

    // Next state: a transfer advances idx (wrapping 15 -> 0); a capture is taken in IDLE or on the final transfer, otherwise dropped as overrun.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovr_d   = ovr_q;
        load_en = 1'b0;
        if (state_q == IDLE) begin
            if (cap_evt) begin
                load_en = 1'b1;
                idx_d   = 4'd0;
                state_d = STREAM;
            end
        end else begin
            if (xfer)
                idx_d = idx_q + 4'd1;
            if (xfer && idx_q == 4'd15) begin
                load_en = cap_evt;
                state_d = cap_evt ? STREAM : IDLE;
            end else if (cap_evt) begin
                ovr_d = 1'b1;
            end
        end
    end

    // Control registers: state, bin index, completion edge detector and sticky overrun flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= i_FFT_cycle_done;
            ovr_q   <= ovr_d;
        end
    end

    // Snapshot buffer: all 16 bins loaded together so the FFT is free to start its next cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            re_q <= '{default: '0};
            im_q <= '{default: '0};
        end else if (load_en) begin
            re_q <= in_re;
            im_q <= in_im;
        end
    end

    assign o_valid   = (state_q == STREAM);
    assign o_busy    = o_valid;
    assign o_idx     = idx_q;
    assign o_re      = re_q[idx_q];
    assign o_im      = im_q[idx_q];
    assign o_last    = o_valid & (idx_q == 4'd15);
    assign o_overrun = ovr_q;

`ifdef FFT16_STREAM_MAG_EN
    logic [WORD_SIZE-1:0] abs_re, abs_im, mx, mn;

    // Unsigned W-bit magnitudes keep |-2^(W-1)| exact; max + min/2 never overflows W+1 bits.
    assign abs_re = o_re[WORD_SIZE-1] ? -o_re : o_re;
    assign abs_im = o_im[WORD_SIZE-1] ? -o_im : o_im;
    assign mx     = (abs_re > abs_im) ? abs_re : abs_im;
    assign mn     = (abs_re > abs_im) ? abs_im : abs_re;
    assign o_mag  = o_valid ? ({1'b0, mx} + {1'b0, mn >> 1}) : '0;
`endif

endmodule

// File: tb/tb_fft16_result_streamer.sv
// tb_fft16_result_streamer: directed self-checking bench for fft16_result_streamer (also covers o_mag when FFT16_STREAM_MAG_EN is defined).
module tb_fft16_result_streamer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         done;
    logic         ready;
    logic [W-1:0] in_re [16];
    logic [W-1:0] in_im [16];
    logic         valid, last, busy, overrun;
    logic [3:0]   idx;
    logic [W-1:0] o_re, o_im;
`ifdef FFT16_STREAM_MAG_EN
    logic [W:0]   mag;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fft16_result_streamer #(.WORD_SIZE(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_FFT_cycle_done(done),
        .in0_re(in_re[0]),   .in0_im(in_im[0]),   .in1_re(in_re[1]),   .in1_im(in_im[1]),
        .in2_re(in_re[2]),   .in2_im(in_im[2]),   .in3_re(in_re[3]),   .in3_im(in_im[3]),
        .in4_re(in_re[4]),   .in4_im(in_im[4]),   .in5_re(in_re[5]),   .in5_im(in_im[5]),
        .in6_re(in_re[6]),   .in6_im(in_im[6]),   .in7_re(in_re[7]),   .in7_im(in_im[7]),
        .in8_re(in_re[8]),   .in8_im(in_im[8]),   .in9_re(in_re[9]),   .in9_im(in_im[9]),
        .in10_re(in_re[10]), .in10_im(in_im[10]), .in11_re(in_re[11]), .in11_im(in_im[11]),
        .in12_re(in_re[12]), .in12_im(in_im[12]), .in13_re(in_re[13]), .in13_im(in_im[13]),
        .in14_re(in_re[14]), .in14_im(in_im[14]), .in15_re(in_re[15]), .in15_im(in_im[15]),
        .o_valid(valid), .i_ready(ready), .o_idx(idx), .o_re(o_re), .o_im(o_im),
        .o_last(last), .o_busy(busy),
`ifdef FFT16_STREAM_MAG_EN
        .o_mag(mag),
`endif
        .o_overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame 0: re = K*256, im = -K. Frame 1: re = 0x1000+K, im = 0x2000+K.
    function automatic logic [W-1:0] ere(input int f, input int k);
        return (f == 0) ? W'(k * 256) : W'(16'h1000 + k);
    endfunction

    function automatic logic [W-1:0] eim(input int f, input int k);
        return (f == 0) ? W'(-k) : W'(16'h2000 + k);
    endfunction

    task automatic load(input int f);
        for (int k = 0; k < 16; k++) begin
            in_re[k] = ere(f, k);
            in_im[k] = eim(f, k);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic beat(input string tag, input int f, input int k);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_idx"}, 32'(idx), 32'(k));
        chk({tag, "_re"}, 32'(o_re), 32'(ere(f, k)));
        chk({tag, "_im"}, 32'(o_im), 32'(eim(f, k)));
        chk({tag, "_last"}, 32'(last), 32'(k == 15));
    endtask

    initial begin
        int cnt;
        int cyc;
        logic       pv, pr;
        logic [3:0] pidx;
        logic [W-1:0] pre;
        rst_n = 1'b1;
        done  = 1'b0;
        ready = 1'b0;
        load(0);
        tick();
        do_reset();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_re", 32'(o_re), 32'd0);
        chk("rst_im", 32'(o_im), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
`ifdef FFT16_STREAM_MAG_EN
        chk("rst_mag", 32'(mag), 32'd0);
`endif

        // Basic frame at full throughput.
        ready = 1'b1;
        tick();
        chk("idle_ignores_ready", 32'(valid), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            beat("basic", 0, k);
            chk("basic_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("basic_end_valid", 32'(valid), 32'd0);
        chk("basic_end_busy", 32'(busy), 32'd0);
        chk("basic_ovr", 32'(overrun), 32'd0);

        // Backpressure with ready pattern 1,0,0,1 repeating.
        load(1);
        ready = 1'b0;
        done  = 1'b1;
        tick();
        done = 1'b0;
        cnt  = 0;
        pv   = 1'b0;
        pr   = 1'b0;
        pidx = '0;
        pre  = '0;
        for (cyc = 0; cyc < 200 && cnt < 16; cyc++) begin
            if (pv && !pr) begin
                chk("bp_hold_idx", 32'(idx), 32'(pidx));
                chk("bp_hold_re", 32'(o_re), 32'(pre));
            end
            ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (valid && ready) begin
                beat("bp", 1, cnt);
                cnt++;
            end
            pv = valid; pr = ready; pidx = idx; pre = o_re;
            tick();
        end
        chk("bp_count", 32'(cnt), 32'd16);
        chk("bp_end_valid", 32'(valid), 32'd0);

        // Overrun: second capture while presenting idx 5 is dropped.
        load(0);
        ready = 1'b1;
        done  = 1'b1;
        tick();
        done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            beat("ovr", 0, k);
            if (k == 5) begin
                load(1);
                done = 1'b1;
            end
            if (k == 6) begin
                done = 1'b0;
                chk("ovr_set", 32'(overrun), 32'd1);
            end
            tick();
        end
        chk("ovr_no_restart", 32'(valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        do_reset();
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Capture coinciding with the idx 15 transfer: back-to-back frames.
        load(0);
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            beat("b2b_a", 0, k);
            if (k == 15) begin
                load(1);
                done = 1'b1;
            end
            tick();
        end
        done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            beat("b2b_b", 1, k);
            chk("b2b_ovr", 32'(overrun), 32'd0);
            tick();
        end
        chk("b2b_end_valid", 32'(valid), 32'd0);

        // Done held high for 40 cycles yields exactly one frame.
        load(0);
        done = 1'b1;
        cnt  = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (valid && ready) cnt++;
        end
        done = 1'b0;
        chk("held_frames", 32'(cnt), 32'd16);
        tick();
        chk("held_idle", 32'(valid), 32'd0);

        // Reset mid-stream at idx 7 aborts the frame for good.
        done = 1'b1;
        tick();
        done = 1'b0;
        for (cyc = 0; cyc < 40 && !(valid && idx == 4'd7); cyc++) tick();
        chk("mid_reached7", 32'(idx), 32'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_idx", 32'(idx), 32'd0);
        chk("mid_rst_re", 32'(o_re), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        tick();
        tick();
        chk("mid_no_resume", 32'(valid), 32'd0);

`ifdef FFT16_STREAM_MAG_EN
        // Magnitude estimate: (0x0300, -1024) -> 1408; (0x8000, 0) -> 32768.
        load(0);
        in_re[0] = 16'h0300; in_im[0] = 16'hFC00;
        in_re[1] = 16'h8000; in_im[1] = 16'h0000;
        ready = 1'b0;
        done  = 1'b1;
        tick();
        done = 1'b0;
        chk("mag_bin0", 32'(mag), 32'd1408);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("mag_bin1", 32'(mag), 32'd32768);
        do_reset();
        chk("mag_idle", 32'(mag), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
